// File: rtl/cfg_reg_pkg.sv
// Shared constants for the configuration register bank: fixed addresses,
// command codes and the decoded command kinds.
package cfg_reg_pkg;

  localparam int CTRL_ADDR    = 0;
  localparam int CMD_ADDR     = 1;
  localparam int FIRST_SHADOW = 2;
  localparam int CNT_W        = 16;

  localparam logic [15:0] CMD_CYC_TRG = 16'h0060;
  localparam logic [15:0] CMD_RST     = 16'h0055;
  localparam logic [15:0] CMD_COMMIT  = 16'h00C3;

  typedef enum logic [1:0] {
    CMD_KIND_OTHER,
    CMD_KIND_CYC,
    CMD_KIND_RST,
    CMD_KIND_COMMIT
  } cmd_kind_e;

endpackage

// File: rtl/cfg_sat_cnt.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module cfg_sat_cnt
  import cfg_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfg_reg_bank.sv
// Shadowed configuration register bank: CTRL/CMD written directly, the rest
// staged in shadow copies and moved to the active image by a COMMIT command.
module cfg_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 32,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_in,
  input  logic [ADDR_W-1:0]          wr_addr_in,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd_in,
  input  logic [ADDR_W-1:0]          rd_addr_in,
  input  logic                       rd_shadow_in,
  output logic [DATA_W-1:0]          rd_data_out,
  output logic                       rd_valid_out,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       trg_enb_out,
  output logic                       cmd_rst_out,
  output logic                       cycled_trg_bgn_out,
  output logic                       commit_done_out,
  output logic [CNT_W-1:0]           config_received_out,
  output logic [CNT_W-1:0]           config_rejected_out
);

  // One extra bit so NUM_REGS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              cmd_rst_q;
  logic              cyc_trg_q;
  logic              commit_done_q;
  logic              trg_enb;
  logic              wr_in_range;
  logic              wr_is_ctrl;
  logic              wr_is_cmd;
  logic              wr_locked;
  logic              wr_ok;
  logic              wr_bad;
  cmd_kind_e         cmd_kind;

  assign trg_enb     = active_q[CTRL_ADDR][0];
  assign wr_in_range = {1'b0, wr_addr_in} < REG_LIMIT;
  assign wr_is_ctrl  = wr_addr_in == ADDR_W'(CTRL_ADDR);
  assign wr_is_cmd   = wr_addr_in == ADDR_W'(CMD_ADDR);

  always_comb begin
    cmd_kind = CMD_KIND_OTHER;
    if (data_in == DATA_W'(CMD_CYC_TRG)) cmd_kind = CMD_KIND_CYC;
    else if (data_in == DATA_W'(CMD_RST)) cmd_kind = CMD_KIND_RST;
    else if (data_in == DATA_W'(CMD_COMMIT)) cmd_kind = CMD_KIND_COMMIT;
  end

  // While triggering is enabled the staged configuration is frozen.
  assign wr_locked = trg_enb &&
                     (!(wr_is_ctrl || wr_is_cmd) ||
                      (wr_is_cmd && (cmd_kind == CMD_KIND_COMMIT)));
  assign wr_ok  = wr_in && wr_in_range && !wr_locked;
  assign wr_bad = wr_in && !wr_ok;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr_in == ADDR_W'(k)) begin
        rd_mux = (k >= FIRST_SHADOW && rd_shadow_in) ? shadow_q[k] : active_q[k];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= RST_VALS[k*DATA_W +: DATA_W];
        active_q[k] <= RST_VALS[k*DATA_W +: DATA_W];
      end
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      cmd_rst_q     <= 1'b0;
      cyc_trg_q     <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      cmd_rst_q     <= 1'b0;
      cyc_trg_q     <= 1'b0;
      commit_done_q <= 1'b0;
      rd_valid_q    <= rd_in;
      if (rd_in) begin
        rd_data_q <= rd_mux;
      end
      if (wr_ok) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (wr_addr_in == ADDR_W'(k)) begin
            if (k < FIRST_SHADOW) active_q[k] <= data_in;
            else                  shadow_q[k] <= data_in;
          end
        end
        if (wr_is_cmd) begin
          unique case (cmd_kind)
            CMD_KIND_CYC: cyc_trg_q <= 1'b1;
            CMD_KIND_RST: cmd_rst_q <= 1'b1;
            CMD_KIND_COMMIT: begin
              for (int k = FIRST_SHADOW; k < NUM_REGS; k++) begin
                active_q[k] <= shadow_q[k];
              end
              commit_done_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_image
    assign regs_out[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign rd_data_out        = rd_data_q;
  assign rd_valid_out       = rd_valid_q;
  assign trg_enb_out        = trg_enb;
  assign cmd_rst_out        = cmd_rst_q;
  assign cycled_trg_bgn_out = cyc_trg_q;
  assign commit_done_out    = commit_done_q;

  cfg_sat_cnt u_rx_cnt (
    .clk   (clk_in),
    .rst   (rst_in),
    .inc   (wr_ok),
    .count (config_received_out)
  );

  cfg_sat_cnt u_rj_cnt (
    .clk   (clk_in),
    .rst   (rst_in),
    .inc   (wr_bad),
    .count (config_rejected_out)
  );

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank: directed writes/reads, with read data and command
// pulses checked by a negedge monitor against queued expectations.
module tb_cfg_reg_bank;
  import cfg_reg_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NR = 32;
  localparam logic [NR*DW-1:0] RV = ({{(NR*DW-16){1'b0}}, 16'h1234} << (5*DW)) |
                                    ({{(NR*DW-16){1'b0}}, 16'hA5A5} << (7*DW));

  localparam logic [2:0] P_NONE   = 3'b000;
  localparam logic [2:0] P_RST    = 3'b100;
  localparam logic [2:0] P_CYC    = 3'b010;
  localparam logic [2:0] P_COMMIT = 3'b001;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              wr_in;
  logic [AW-1:0]     wr_addr_in;
  logic [DW-1:0]     data_in;
  logic              rd_in;
  logic [AW-1:0]     rd_addr_in;
  logic              rd_shadow_in;
  logic [DW-1:0]     rd_data_out;
  logic              rd_valid_out;
  logic [NR*DW-1:0]  regs_out;
  logic              trg_enb_out;
  logic              cmd_rst_out;
  logic              cycled_trg_bgn_out;
  logic              commit_done_out;
  logic [15:0]       config_received_out;
  logic [15:0]       config_rejected_out;

  cfg_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RST_VALS(RV)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_in(wr_in), .wr_addr_in(wr_addr_in),
    .data_in(data_in), .rd_in(rd_in), .rd_addr_in(rd_addr_in),
    .rd_shadow_in(rd_shadow_in), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .regs_out(regs_out), .trg_enb_out(trg_enb_out),
    .cmd_rst_out(cmd_rst_out), .cycled_trg_bgn_out(cycled_trg_bgn_out),
    .commit_done_out(commit_done_out), .config_received_out(config_received_out),
    .config_rejected_out(config_rejected_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [DW-1:0] data; int at; } rd_exp_t;
  typedef struct { logic [2:0] code; int at; } pl_exp_t;

  rd_exp_t rd_q[$];
  pl_exp_t pl_q[$];
  rd_exp_t re;
  pl_exp_t pe;
  logic [2:0] pl;

  always @(posedge clk_in) cyc++;

  // Monitor: every presented output must match the head of its queue at the
  // expected cycle; an expectation left behind its cycle is a miss.
  always @(negedge clk_in) begin
    if (rd_valid_out === 1'b1) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_extra: valid with data %h at cycle %0d, none expected", rd_data_out, cyc);
      end else begin
        re = rd_q.pop_front();
        if (rd_data_out !== re.data || cyc != re.at) begin
          bad++;
          $display("FAIL rd_data: got %h at cycle %0d, expected %h at cycle %0d",
                   rd_data_out, cyc, re.data, re.at);
        end
      end
    end
    if (rd_q.size() > 0 && rd_q[0].at < cyc) begin
      total++; bad++;
      re = rd_q.pop_front();
      $display("FAIL rd_missing: no valid at cycle %0d, expected %h", re.at, re.data);
    end
    pl = {cmd_rst_out, cycled_trg_bgn_out, commit_done_out};
    if (pl !== P_NONE) begin
      total++;
      if (pl_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_extra: got %b at cycle %0d, none expected", pl, cyc);
      end else begin
        pe = pl_q.pop_front();
        if (pl !== pe.code || cyc != pe.at) begin
          bad++;
          $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d", pl, cyc, pe.code, pe.at);
        end
      end
    end
    if (pl_q.size() > 0 && pl_q[0].at < cyc) begin
      total++; bad++;
      pe = pl_q.pop_front();
      $display("FAIL pulse_missing: expected %b at cycle %0d", pe.code, pe.at);
    end
  end

  task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic r, input logic [AW-1:0] ra, input logic sh,
                    input logic [DW-1:0] rexp, input logic [2:0] pexp);
    rd_exp_t t;
    pl_exp_t p;
    wr_in = w; wr_addr_in = wa; data_in = wd;
    rd_in = r; rd_addr_in = ra; rd_shadow_in = sh;
    if (r) begin
      t.data = rexp; t.at = cyc + 1;
      rd_q.push_back(t);
    end
    if (pexp != P_NONE) begin
      p.code = pexp; p.at = cyc + 1;
      pl_q.push_back(p);
    end
    @(posedge clk_in); #1;
    wr_in = 1'b0; rd_in = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] pexp);
    op(1'b1, a, d, 1'b0, '0, 1'b0, '0, pexp);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic sh, input logic [DW-1:0] e);
    op(1'b0, '0, '0, 1'b1, a, sh, e, P_NONE);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, P_NONE);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_img(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; wr_in = 1'b0; wr_addr_in = '0; data_in = '0;
    rd_in = 1'b0; rd_addr_in = '0; rd_shadow_in = 1'b0;
    idle(2);
    rst_in = 1'b0;

    check_img("reset_image", regs_out, RV);
    check16("reset_rx", config_received_out, 16'h0000);
    check16("reset_rj", config_rejected_out, 16'h0000);
    check16("reset_trg", {15'b0, trg_enb_out}, 16'h0000);
    check16("reset_valid", {15'b0, rd_valid_out}, 16'h0000);

    rd(8'd5, 1'b1, 16'h1234);
    rd(8'd5, 1'b0, 16'h1234);
    rd(8'd7, 1'b1, 16'hA5A5);

    wr(8'd5, 16'hBEEF, P_NONE);
    rd(8'd5, 1'b1, 16'hBEEF);
    rd(8'd5, 1'b0, 16'h1234);
    check16("pre_commit_slot5", regs_out[5*DW +: DW], 16'h1234);
    wr(8'd1, 16'h00C3, P_COMMIT);
    check16("commit_slot5", regs_out[5*DW +: DW], 16'hBEEF);
    check16("commit_slot1", regs_out[1*DW +: DW], 16'h00C3);
    check16("commit_rx", config_received_out, 16'd2);
    rd(8'd5, 1'b0, 16'hBEEF);

    // Read and write of the same register in one cycle sees the old value.
    op(1'b1, 8'd6, 16'h1111, 1'b1, 8'd6, 1'b1, 16'h0000, P_NONE);
    rd(8'd6, 1'b1, 16'h1111);

    wr(8'd0, 16'h0001, P_NONE);
    check16("trg_enb_on", {15'b0, trg_enb_out}, 16'h0001);
    wr(8'd5, 16'h5555, P_NONE);
    wr(8'd1, 16'h00C3, P_NONE);
    check16("locked_rj", config_rejected_out, 16'd2);
    check16("locked_rx", config_received_out, 16'd4);
    check16("locked_slot1", regs_out[1*DW +: DW], 16'h00C3);
    check16("locked_slot6", regs_out[6*DW +: DW], 16'h0000);
    rd(8'd5, 1'b1, 16'hBEEF);
    rd(8'd5, 1'b0, 16'hBEEF);
    wr(8'd0, 16'h0000, P_NONE);
    check16("trg_enb_off", {15'b0, trg_enb_out}, 16'h0000);

    wr(8'd1, 16'h0055, P_RST);
    wr(8'd1, 16'h0060, P_CYC);
    wr(8'd1, 16'h0042, P_NONE);
    check16("other_cmd_slot1", regs_out[1*DW +: DW], 16'h0042);
    check16("cmd_rx", config_received_out, 16'd8);

    wr(8'd32, 16'hFFFF, P_NONE);
    check16("oor_rj", config_rejected_out, 16'd3);
    rd(8'd32, 1'b1, 16'h0000);
    rd(8'd255, 1'b0, 16'h0000);
    rd(8'd1, 1'b1, 16'h0042);
    rd(8'd0, 1'b1, 16'h0000);

    for (int i = 0; i < 65527; i++) wr(8'd3, 16'h0000, P_NONE);
    check16("sat_reach", config_received_out, 16'hFFFF);
    wr(8'd3, 16'h0001, P_NONE);
    check16("sat_hold", config_received_out, 16'hFFFF);
    check16("sat_rj", config_rejected_out, 16'd3);

    // Reset wins over a concurrent CMD_RST write.
    rst_in = 1'b1;
    wr(8'd1, 16'h0055, P_NONE);
    rst_in = 1'b0;
    check_img("rst_image", regs_out, RV);
    check16("rst_rx", config_received_out, 16'h0000);
    check16("rst_rj", config_rejected_out, 16'h0000);
    idle(1);
    rd(8'd5, 1'b1, 16'h1234);
    rd(8'd7, 1'b0, 16'hA5A5);

    idle(3);
    check16("rd_q_drained", 16'(rd_q.size()), 16'h0000);
    check16("pl_q_drained", 16'(pl_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
